// File: rtl/axis_uart_tx.sv
// AXI-Stream slave to UART transmitter: a small input FIFO feeds a start/data/parity/stop
// serialiser driving the TX pin. Frames go back-to-back while the FIFO holds data.
module axis_uart_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;
    localparam int unsigned BIT_W        = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  r_tready;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  r_par;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_tick;
    logic                  w_frame_end;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_done_next;

    assign w_push       = s_axis_tvalid && r_tready;
    assign w_empty      = (r_count == CNT_W'(0));
    assign w_tick       = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_head       = r_mem[r_rptr];
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign s_axis_tready = r_tready;
    assign uart_tx       = r_tx;
    assign tx_busy       = r_busy;
    assign frame_done    = r_done;
    assign fifo_count    = r_count;

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_axis_tdata;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a pop always coincides with entering START
    always_comb begin : next_state
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_next = START;
                    w_pop        = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bit == BIT_W'(DATA_WIDTH - 1))) begin
                    w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick && (r_bit == BIT_W'(STOP_BITS - 1))) begin
                    w_frame_end = 1'b1;
                    if (!w_empty) begin
                        w_state_next = START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: line level is computed for the upcoming cycle so uart_tx is a flop
    always_comb begin : outputs
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = w_head;
        end else if ((r_state == DATA) && w_tick) begin
            w_shift_next = r_shift >> 1;
        end
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_par;
            default: w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != IDLE);
        w_done_next = w_frame_end;
    end

    // Datapath, FIFO pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_tready <= 1'b1;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_par  <= (^w_head) ^ 1'(PARITY_ODD);
            end
            r_count  <= w_count_next;
            r_tready <= (w_count_next != CNT_W'(FIFO_DEPTH));
            r_shift  <= w_shift_next;
            if ((r_state == IDLE) || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
            if (w_state_next != r_state) begin
                r_bit <= '0;
            end else if (w_tick && ((r_state == DATA) || (r_state == STOP))) begin
                r_bit <= r_bit + BIT_W'(1);
            end
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: four instances (8N1, even parity, odd parity, 2 stop bits)
// at 4 clocks per bit, directed frame vectors plus multi-cycle corner sequences.
module tb_axis_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata [4];
    logic [3:0] tvalid;
    logic [3:0] tready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;
    logic [2:0] cnt_w [4];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [23:0] seq;    // line bits in send order, left-aligned
        int          nbits;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4)) u_8n1 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
        .s_axis_tready(tready_w[0]), .uart_tx(tx_w[0]), .tx_busy(busy_w[0]),
        .frame_done(done_w[0]), .fifo_count(cnt_w[0]));

    axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
        .s_axis_tready(tready_w[1]), .uart_tx(tx_w[1]), .tx_busy(busy_w[1]),
        .frame_done(done_w[1]), .fifo_count(cnt_w[1]));

    axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
        .s_axis_tready(tready_w[2]), .uart_tx(tx_w[2]), .tx_busy(busy_w[2]),
        .frame_done(done_w[2]), .fifo_count(cnt_w[2]));

    axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
        .s_axis_tready(tready_w[3]), .uart_tx(tx_w[3]), .tx_busy(busy_w[3]),
        .frame_done(done_w[3]), .fifo_count(cnt_w[3]));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame8n1(input logic [7:0] d);
        logic [9:0] f;
        f[9] = 1'b0;
        for (int i = 0; i < 8; i++) f[8-i] = d[i];
        f[0] = 1'b1;
        return f;
    endfunction

    // Single-cycle transfer; returns 1 ns after the accepting edge
    task automatic push(input int sel, input logic [7:0] d);
        @(negedge clk);
        tdata[sel]  = d;
        tvalid[sel] = 1'b1;
        @(posedge clk);
        #1 tvalid[sel] = 1'b0;
    endtask

    // Cycle c = negedge after edge E+c, where E is the accepting edge (start bit at c=1)
    task automatic check_line(input int sel, input logic [23:0] seq, input int nbits, input int c0);
        for (int c = c0; c <= nbits*4 + 1; c++) begin
            @(negedge clk);
            if (c == nbits*4 + 1) begin
                cmp($sformatf("frame_done u%0d", sel), 32'(done_w[sel]), 32'd1);
                cmp($sformatf("busy_end u%0d", sel), 32'(busy_w[sel]), 32'd0);
                cmp($sformatf("tx_idle u%0d", sel), 32'(tx_w[sel]), 32'd1);
            end else if (c >= 1 && (c % 4) == 2) begin
                cmp($sformatf("tx_bit u%0d c%0d", sel, c), 32'(tx_w[sel]), 32'(seq[23-(c-1)/4]));
                cmp($sformatf("busy u%0d c%0d", sel, c), 32'(busy_w[sel]), 32'd1);
                cmp($sformatf("no_done u%0d c%0d", sel, c), 32'(done_w[sel]), 32'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int maxc;
        logic rdy;

        vecs[0] = '{0, 8'h3C, {12'b0001_1110_0100, 12'b0}, 10};
        vecs[1] = '{0, 8'hA5, {12'b0101_0010_1100, 12'b0}, 10};
        vecs[2] = '{1, 8'h07, {12'b0111_0000_0110, 12'b0}, 11};
        vecs[3] = '{2, 8'h07, {12'b0111_0000_0010, 12'b0}, 11};
        vecs[4] = '{0, 8'h00, {12'b0000_0000_0100, 12'b0}, 10};
        vecs[5] = '{3, 8'h00, {12'b0000_0000_0110, 12'b0}, 11};
        vecs[6] = '{1, 8'h03, {12'b0110_0000_0010, 12'b0}, 11};
        vecs[7] = '{2, 8'h03, {12'b0110_0000_0110, 12'b0}, 11};

        rst    = 1'b1;
        tvalid = '0;
        for (int k = 0; k < 4; k++) tdata[k] = '0;
        #12;
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("rst_tx u%0d", k), 32'(tx_w[k]), 32'd1);
            cmp($sformatf("rst_busy u%0d", k), 32'(busy_w[k]), 32'd0);
            cmp($sformatf("rst_done u%0d", k), 32'(done_w[k]), 32'd0);
            cmp($sformatf("rst_tready u%0d", k), 32'(tready_w[k]), 32'd1);
            cmp($sformatf("rst_count u%0d", k), 32'(cnt_w[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during data bit 3 with two bytes still queued
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        repeat (17) @(negedge clk);
        cmp("pre_rst_tx", 32'(tx_w[0]), 32'd0);
        cmp("pre_rst_count", 32'(cnt_w[0]), 32'd2);
        cmp("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        cmp("mid_rst_tx", 32'(tx_w[0]), 32'd1);
        cmp("mid_rst_count", 32'(cnt_w[0]), 32'd0);
        cmp("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        cmp("mid_rst_tready", 32'(tready_w[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((i % 10) == 0) begin
                cmp($sformatf("post_rst_tx i%0d", i), 32'(tx_w[0]), 32'd1);
                cmp($sformatf("post_rst_busy i%0d", i), 32'(busy_w[0]), 32'd0);
                cmp($sformatf("post_rst_count i%0d", i), 32'(cnt_w[0]), 32'd0);
            end
        end

        // Single-frame vectors
        for (int v = 0; v < 8; v++) begin
            push(vecs[v].sel, vecs[v].data);
            check_line(vecs[v].sel, vecs[v].seq, vecs[v].nbits, 0);
            repeat (2) @(negedge clk);
        end

        // Two stop bits, 0x00 then 0xFF back-to-back: 88 cycles
        push(3, 8'h00);
        push(3, 8'hFF);
        check_line(3, {11'b000_0000_0011, 11'b011_1111_1111, 2'b00}, 22, 1);
        repeat (2) @(negedge clk);

        // tvalid held with six bytes against a 4-deep FIFO
        acc  = 0;
        maxc = 0;
        fork
            begin
                @(negedge clk);
                tdata[0]  = 8'h01;
                tvalid[0] = 1'b1;
                for (int g = 0; g < 400 && acc < 6; g++) begin
                    rdy = tready_w[0];
                    @(posedge clk);
                    if (rdy) acc++;
                    @(negedge clk);
                    if (rdy && acc == 5) cmp("tready_full", 32'(tready_w[0]), 32'd0);
                    if (acc == 6) tvalid[0] = 1'b0;
                    else tdata[0] = 8'(acc + 1);
                end
                tvalid[0] = 1'b0;
                cmp("accepted", 32'(acc), 32'd6);
            end
            begin
                logic [9:0] fr;
                @(negedge clk);
                @(posedge clk);
                for (int c = 0; c <= 241; c++) begin
                    @(negedge clk);
                    if (int'(cnt_w[0]) > maxc) maxc = int'(cnt_w[0]);
                    if (c == 241) begin
                        cmp("stream_done", 32'(done_w[0]), 32'd1);
                        cmp("stream_busy_end", 32'(busy_w[0]), 32'd0);
                    end else if (c >= 1 && (c % 4) == 2) begin
                        fr = frame8n1(8'((c-1)/40 + 1));
                        cmp($sformatf("stream_tx c%0d", c), 32'(tx_w[0]), 32'(fr[9-((c-1)%40)/4]));
                        cmp($sformatf("stream_busy c%0d", c), 32'(busy_w[0]), 32'd1);
                    end
                end
            end
        join
        cmp("max_count", 32'(maxc), 32'd4);
        repeat (2) @(negedge clk);

        // Push landing on the final stop edge while one byte is queued
        push(0, 8'h5A);
        push(0, 8'h81);
        repeat (40) @(negedge clk);
        cmp("edge_pre_count", 32'(cnt_w[0]), 32'd1);
        cmp("edge_pre_tx", 32'(tx_w[0]), 32'd1);
        cmp("edge_pre_done", 32'(done_w[0]), 32'd0);
        tdata[0]  = 8'hC3;
        tvalid[0] = 1'b1;
        @(posedge clk);
        #1 tvalid[0] = 1'b0;
        @(negedge clk);
        cmp("edge_count", 32'(cnt_w[0]), 32'd1);
        cmp("edge_done", 32'(done_w[0]), 32'd1);
        cmp("edge_start_tx", 32'(tx_w[0]), 32'd0);
        cmp("edge_busy", 32'(busy_w[0]), 32'd1);
        check_line(0, {frame8n1(8'h81), frame8n1(8'hC3), 4'b0000}, 20, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
